// File: rtl/mem_responder_pkg.sv
// Shared definitions for the MAR/MDR memory responder: FSM states,
// default geometry/timing and the data-word width.
package mem_pkg;

   localparam int unsigned MEM_ADDR_W      = 9;
   localparam int unsigned MEM_DEPTH       = 384;
   localparam int unsigned MEM_WAIT_CYCLES = 2;
   localparam int unsigned DATA_W          = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and the
// memory responder (slave). err exists only with MEM_BOUNDS_CHECK_EN.
interface mem_responder_if
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = MEM_ADDR_W
);

   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              done;
   logic              busy;
`ifdef MEM_BOUNDS_CHECK_EN
   logic              err;

   modport master (output read, write, addr, wdata,
                   input  rdata, done, busy, err);
   modport slave  (input  read, write, addr, wdata,
                   output rdata, done, busy, err);
`else
   modport master (output read, write, addr, wdata,
                   input  rdata, done, busy);
   modport slave  (input  read, write, addr, wdata,
                   output rdata, done, busy);
`endif

endinterface

// File: rtl/mem_responder_array.sv
// Single-port word storage with write-enable and registered read output,
// shaped for block-RAM inference. Contents are never reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = MEM_ADDR_W,
   parameter int unsigned DEPTH  = MEM_DEPTH
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[a] <= d;
         else    q      <= mem[a];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write in IDLE, waits WAIT_CYCLES,
// performs the access and pulses done. Optional macro: MEM_BOUNDS_CHECK_EN.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = MEM_ADDR_W,
   parameter int unsigned DEPTH       = MEM_DEPTH,
   parameter int unsigned WAIT_CYCLES = MEM_WAIT_CYCLES
) (
   input logic            clk,
   input logic            clr,
   mem_responder_if.slave bus
);

   mem_state_t        state, state_nx;
   logic [3:0]        cnt;
   logic              op_wr;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] q;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rdata_r;
   logic              accept;
   logic              access;
   logic              oob;
   logic              rd_done;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      access   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.read || bus.write) begin
               accept   = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               access   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt     <= '0;
         op_wr   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_r <= '0;
      end else begin
         if (accept) begin
            cnt     <= 4'(WAIT_CYCLES);
            op_wr   <= bus.write;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 4'd1;
         end
         if (rd_done) rdata_r <= rd_word;
      end
   end

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob     = {1'b0, addr_q} >= (ADDR_W+1)'(DEPTH);
   assign bus.err = (state == DONE) && oob;
`else
   assign oob     = 1'b0;
`endif

   // Address wraps modulo DEPTH so a non-power-of-two depth never indexes past the array.
   assign idx = ADDR_W'({1'b0, addr_q} % (ADDR_W+1)'(DEPTH));

   mem_array #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk (clk),
      .en  (access && !oob),
      .we  (op_wr),
      .a   (idx),
      .d   (wdata_q),
      .q   (q)
   );

   // Registered RAM output is only valid in DONE; rdata_r captures it there so it holds afterwards.
   assign rd_done   = (state == DONE) && !op_wr;
   assign rd_word   = oob ? '0 : q;
   assign bus.rdata = rd_done ? rd_word : rdata_r;
   assign bus.done  = (state == DONE);
   assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table of transactions plus
// hand sequences for held strobe, clr abort, zero wait states and bounds.
module tb_mem_responder;
   import mem_pkg::*;

   localparam int unsigned AW = 9;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   mem_responder_if #(.ADDR_W(AW)) bus ();
   mem_responder_if #(.ADDR_W(AW)) bus0 ();

   mem_responder #(.ADDR_W(AW), .DEPTH(384), .WAIT_CYCLES(2)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   mem_responder #(.ADDR_W(AW), .DEPTH(384), .WAIT_CYCLES(0)) dut0 (
      .clk (clk),
      .clr (clr),
      .bus (bus0)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [31:0] d);
      if (sel) begin
         bus0.read = rd; bus0.write = wr; bus0.addr = a; bus0.wdata = d;
      end else begin
         bus.read = rd;  bus.write = wr;  bus.addr = a;  bus.wdata = d;
      end
   endtask

   // One transaction from IDLE; lat_exp counts negedge samples after the accept edge.
   task automatic xact(input string name, input bit sel, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [31:0] d,
                       input int lat_exp, input logic [31:0] rd_exp);
      bit          busy_ok = 1'b1;
      int          lat     = 0;
      logic        dn, bz;
      logic [31:0] rv      = '0;
`ifdef MEM_BOUNDS_CHECK_EN
      logic        ev      = 1'b0;
      logic        eo;
      logic        err_exp = (a >= AW'(384));
`endif
      @(negedge clk); drive(sel, rd, wr, a, d);
      @(posedge clk);
      @(negedge clk); drive(sel, 1'b0, 1'b0, a, d);
      for (int k = 1; k <= 20; k++) begin
         dn = sel ? bus0.done : bus.done;
         bz = sel ? bus0.busy : bus.busy;
         if (dn) begin
            lat = k;
            rv  = sel ? bus0.rdata : bus.rdata;
`ifdef MEM_BOUNDS_CHECK_EN
            ev  = sel ? bus0.err : bus.err;
`endif
            break;
         end
         if (!bz) busy_ok = 1'b0;
         @(negedge clk);
      end
      check({name, " latency"}, 32'(lat), 32'(lat_exp));
      check({name, " rdata@done"}, rv, rd_exp);
      check({name, " busy before done"}, 32'(busy_ok), 32'd1);
`ifdef MEM_BOUNDS_CHECK_EN
      check({name, " err@done"}, 32'(ev), 32'(err_exp));
`endif
      @(negedge clk);
      dn = sel ? bus0.done : bus.done;
      bz = sel ? bus0.busy : bus.busy;
`ifdef MEM_BOUNDS_CHECK_EN
      eo = sel ? bus0.err : bus.err;
      check({name, " idle after {done,busy,err}"}, {29'b0, dn, bz, eo}, 32'd0);
`else
      check({name, " idle after {done,busy}"}, {30'b0, dn, bz}, 32'd0);
`endif
      check({name, " rdata hold"}, sel ? bus0.rdata : bus.rdata, rd_exp);
   endtask

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic [31:0]   exp;
   } vec_t;

   vec_t vt[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          last;
      int          ndone;
      bit          gap_ok;
      bit          rd_ok;
      bit          saw;

      // rd, wr, addr, wdata, expected rdata at done (writes leave rdata unchanged)
      vt[0]  = '{1'b0, 1'b1, 9'd5,   32'hDEADBEEF, 32'h00000000};
      vt[1]  = '{1'b1, 1'b0, 9'd5,   32'h00000000, 32'hDEADBEEF};
      vt[2]  = '{1'b1, 1'b1, 9'd7,   32'h12345678, 32'hDEADBEEF};
      vt[3]  = '{1'b1, 1'b0, 9'd7,   32'h00000000, 32'h12345678};
      vt[4]  = '{1'b0, 1'b1, 9'd9,   32'h11111111, 32'h12345678};
      vt[5]  = '{1'b0, 1'b1, 9'd383, 32'h0BADF00D, 32'h12345678};
      vt[6]  = '{1'b1, 1'b0, 9'd383, 32'h00000000, 32'h0BADF00D};
      vt[7]  = '{1'b0, 1'b1, 9'd0,   32'h00000001, 32'h0BADF00D};
      vt[8]  = '{1'b1, 1'b0, 9'd0,   32'h00000000, 32'h00000001};
      vt[9]  = '{1'b1, 1'b0, 9'd5,   32'h00000000, 32'hDEADBEEF};
      vt[10] = '{1'b1, 1'b0, 9'd9,   32'h00000000, 32'h11111111};

      clr = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (2) @(negedge clk);
      check("reset busy",  32'(bus.busy),  32'd0);
      check("reset done",  32'(bus.done),  32'd0);
      check("reset rdata", bus.rdata,      32'd0);
      check("reset0 busy", 32'(bus0.busy), 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
      check("reset err",   32'(bus.err),   32'd0);
`endif
      clr = 1'b0;

      for (int i = 0; i < 11; i++)
         xact($sformatf("vec%0d", i), 1'b0, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, 4, vt[i].exp);

      // held read strobe: one done every WAIT_CYCLES+3 = 5 cycles
      @(negedge clk); drive(1'b0, 1'b1, 1'b0, 9'd7, '0);
      last = -1; ndone = 0; gap_ok = 1'b1; rd_ok = 1'b1;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (bus.done) begin
            if (last >= 0 && c - last != 5) gap_ok = 1'b0;
            if (bus.rdata !== 32'h12345678) rd_ok = 1'b0;
            last = c;
            ndone++;
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      check("held done count",   32'(ndone),  32'd6);
      check("held done spacing", 32'(gap_ok), 32'd1);
      check("held rdata",        32'(rd_ok),  32'd1);
      for (int c = 0; c < 20; c++) begin
         if (!bus.busy) break;
         @(negedge clk);
      end
      check("held drain idle", 32'(bus.busy), 32'd0);

      // clr in WAIT of a write to 9 must drop the write
      @(negedge clk); drive(1'b0, 1'b0, 1'b1, 9'd9, 32'hAAAA5555);
      @(posedge clk);
      @(negedge clk); drive(1'b0, 1'b0, 1'b0, 9'd9, '0);
      check("abort busy pre-clr", 32'(bus.busy), 32'd1);
      @(negedge clk);
      clr = 1'b1;
      #1;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort rdata", bus.rdata,    32'd0);
      @(negedge clk); clr = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.done) saw = 1'b1;
      end
      check("abort no done", 32'(saw), 32'd0);
      xact("abort readback", 1'b0, 1'b1, 1'b0, 9'd9, '0, 4, 32'h11111111);

      // zero wait states: done after edge t+1
      xact("wc0 write", 1'b1, 1'b0, 1'b1, 9'd0, 32'h5A5A0F0F, 2, 32'h00000000);
      xact("wc0 read",  1'b1, 1'b1, 1'b0, 9'd0, 32'h00000000, 2, 32'h5A5A0F0F);

`ifdef MEM_BOUNDS_CHECK_EN
      xact("oob pre16",  1'b0, 1'b0, 1'b1, 9'd16,  32'h16161616, 4, 32'h11111111);
      xact("oob wr400",  1'b0, 1'b0, 1'b1, 9'd400, 32'hFFFFFFFF, 4, 32'h11111111);
      xact("oob rd400",  1'b0, 1'b1, 1'b0, 9'd400, 32'h00000000, 4, 32'h00000000);
      xact("oob rd16",   1'b0, 1'b1, 1'b0, 9'd16,  32'h00000000, 4, 32'h16161616);
`else
      xact("wrap pre16", 1'b0, 1'b0, 1'b1, 9'd16,  32'h16161616, 4, 32'h11111111);
      xact("wrap wr400", 1'b0, 1'b0, 1'b1, 9'd400, 32'hCAFEF00D, 4, 32'h11111111);
      xact("wrap rd16",  1'b0, 1'b1, 1'b0, 9'd16,  32'h00000000, 4, 32'hCAFEF00D);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
